// File: rtl/sched_mux_rr.sv
// N-channel scheduling multiplexer: fixed-select, fixed-priority or round-robin
// arbitration feeding a single registered output stage with backpressure.
module sched_mux_rr #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_valid,
  output logic [N_CH-1:0]     in_ready,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [W-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SEL_W-1:0]    out_ch
);

  // Handshake: a word moves on any edge where valid & ready are both high.
  // in_ready is a function of in_valid (grant), never the reverse, so sources
  // must hold in_valid independent of in_ready to avoid combinational loops.

  localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] last;
  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [W-1:0]     grant_data;
  logic             transfer;

  assign load_en  = ~out_valid | out_ready;
  assign transfer = grant_valid & load_en & ~rst;

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    case (mode)
      2'b00: begin
        for (int i = 0; i < N_CH; i++) begin
          if (int'(sel) == i && in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = i[SEL_W-1:0];
          end
        end
      end
      2'b10: begin
        // Walk the search order backwards so the nearest channel after 'last' wins.
        for (int k = N_CH; k >= 1; k--) begin
          idx = (int'(last) + k) % N_CH;
          if (in_valid[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx[SEL_W-1:0];
          end
        end
      end
      default: begin
        for (int i = N_CH - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = i[SEL_W-1:0];
          end
        end
      end
    endcase
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == i[SEL_W-1:0]) begin
        grant_data  = in_data[i*W +: W];
        in_ready[i] = transfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= LAST_INIT;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_idx;
      if (mode == 2'b10) begin
        last <= grant_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sched_mux_rr.sv
// Randomized and directed bench for sched_mux_rr against a list-based
// arbitration model and an output-word scoreboard.
module tb_sched_mux_rr;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  logic                clk;
  logic                rst;
  logic [N_CH*W-1:0]   in_data;
  logic [N_CH-1:0]     in_valid;
  logic [N_CH-1:0]     in_ready;
  logic [1:0]          mode;
  logic [SEL_W-1:0]    sel;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic [SEL_W-1:0]    out_ch;

  sched_mux_rr #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_valid;
  int m_data;
  int m_ch;
  int m_last;
  logic [W+SEL_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int chan_data(input int ch);
    return int'(in_data[ch*W +: W]);
  endfunction

  // Arbitration from the rules: build the search order, take the first valid.
  function automatic int model_grant();
    int order[$];
    if (mode == 2'b00) begin
      if (int'(sel) < N_CH && in_valid[sel]) return int'(sel);
      return -1;
    end
    if (mode == 2'b10) begin
      for (int k = 1; k <= N_CH; k++) order.push_back((m_last + k) % N_CH);
    end else begin
      for (int k = 0; k < N_CH; k++) order.push_back(k);
    end
    foreach (order[j]) if (in_valid[order[j]]) return order[j];
    return -1;
  endfunction

  // One clock: check the combinational side, clock, then check the register side.
  task automatic cycle();
    int g;
    int can_load;
    logic [N_CH-1:0] exp_ready;
    logic [W+SEL_W-1:0] word;
    #1;
    g = model_grant();
    can_load = (m_valid == 0 || out_ready) && !rst;
    exp_ready = '0;
    if (g >= 0 && can_load != 0) exp_ready[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    if (m_valid != 0 && out_ready && !rst) begin
      check("sb_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        word = exp_q.pop_front();
        check("sb_data", 32'(out_data), 32'(word[W-1:0]));
        check("sb_ch", 32'(out_ch), 32'(word[W+SEL_W-1:W]));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_last = N_CH - 1;
      exp_q.delete();
    end else if (g >= 0 && can_load != 0) begin
      m_valid = 1; m_data = chan_data(g); m_ch = g;
      if (mode == 2'b10) m_last = g;
      exp_q.push_back({SEL_W'(g), W'(m_data)});
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_ch", 32'(out_ch), 32'(m_ch));
    @(negedge clk);
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic [1:0] md, input logic [SEL_W-1:0] s,
                       input logic [N_CH-1:0] v, input logic ordy);
    rst = r; mode = md; sel = s; in_valid = v; out_ready = ordy;
  endtask

  task automatic set_data_default();
    for (int i = 0; i < N_CH; i++) in_data[i*W +: W] = W'((i + 1) * 16);
  endtask

  initial begin
    m_valid = 0; m_data = 0; m_ch = 0; m_last = N_CH - 1;
    in_data = '0;
    drive(1'b1, 2'b10, '0, '1, 1'b1);
    set_data_default();
    @(negedge clk);

    // reset, then round-robin over all valid channels
    cycle();
    cycle();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_seq_ch", 32'(out_ch), 32'(k % 4));
      check("rr_seq_data", 32'(out_data), 32'((k % 4 + 1) * 16));
    end

    // fixed priority: ch1 shadows ch3
    drive(1'b0, 2'b01, '0, 4'b1010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("prio_ch", 32'(out_ch), 32'd1);
    end

    // fixed select on an idle channel drains the output, then picks it up
    drive(1'b0, 2'b00, 2'd2, 4'b1011, 1'b1);
    for (int k = 0; k < 3; k++) cycle();
    check("sel_idle_valid", 32'(out_valid), 32'd0);
    in_valid[2] = 1'b1;
    in_data[2*W +: W] = 8'hA5;
    cycle();
    check("sel_data", 32'(out_data), 32'hA5);
    check("sel_ch", 32'(out_ch), 32'd2);
    set_data_default();

    // backpressure in round-robin
    drive(1'b0, 2'b10, '0, '1, 1'b1);
    cycle();
    cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) cycle();

    // pointer survives a detour through fixed priority
    drive(1'b1, 2'b10, '0, '1, 1'b1);
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    mode = 2'b01;
    cycle();
    cycle();
    check("switch_prio_ch", 32'(out_ch), 32'd0);
    mode = 2'b10;
    cycle();
    check("switch_rr_ch", 32'(out_ch), 32'd3);

    // reset while stalled with a held word
    out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("midrst_first_ch", 32'(out_ch), 32'd0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mode      = 2'($urandom_range(0, 3));
      sel       = SEL_W'($urandom_range(0, N_CH - 1));
      in_valid  = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N_CH; i++) in_data[i*W +: W] = W'($urandom_range(0, 255));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
